// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial A - B - Bin, one bit per clock, LSB first.
// An operation takes WIDTH shift cycles plus one DONE cycle. Diff/Bout only
// change when an operation completes, so partial sums are never visible.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the registered
// signed-overflow output Ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] res_sh;
    logic             borrow;
    logic [CW-1:0]    count;

    logic             a0;
    logic             b0;
    logic             d;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // One full-subtractor slice on the current LSBs of the operand registers
    always_comb begin
        a0       = a_sh[0];
        b0       = b_sh[0];
        d        = a0 ^ b0 ^ borrow;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & borrow);
        res_next = {d, res_sh};
        last_bit = (count == CW'(WIDTH - 1));
    end

    // Control FSM plus datapath; outputs are registered alongside the state
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            borrow <= 1'b0;
            count  <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Diff   <= '0;
            Bout   <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            Ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        a_sh   <= A;
                        b_sh   <= B;
                        borrow <= Bin;
                        count  <= '0;
                        Busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sh <= res_next[WIDTH-1:1];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    borrow <= br_next;
                    count  <= count + CW'(1);
                    if (last_bit) begin
                        Diff  <= res_next;
                        Bout  <= br_next;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        Ovf   <= (a0 ^ b0) & (a0 ^ d);
`endif
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
